// File: rtl/uart_tx_fifo.sv
// Byte-buffered UART transmitter: a FIFO of FIFO_DEPTH bytes feeding an 8N1 serializer.
// Frames are exactly 10*CPB cycles and run back to back while bytes remain buffered.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_data_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB    = CLK_FREQ / BAUD_RATE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CPB);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0] mem [FIFO_DEPTH];

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic push;
    logic pop;
    logic baud_done;
    logic start_frame;

    assign tx_ready   = (count_q != FULL_COUNT);
    assign push       = tx_data_valid && tx_ready;
    assign baud_done  = (baud_cnt_q == BAUD_LAST);
    assign tx         = tx_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        start_frame = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (count_q != '0) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading the next byte from STOP skips IDLE so frames stay contiguous.
        if (start_frame) begin
            shift_d    = mem[rd_ptr_q];
            bit_idx_d  = '0;
            baud_cnt_d = '0;
            state_d    = START;
            tx_d       = 1'b0;
        end
    end

    assign pop = start_frame;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: a frame-level reference model predicts the line,
// buffer occupancy and flags every cycle; a line decoder checks bytes against accepted order.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int DEPTH     = 4;
    localparam int FRAME     = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_ready     (tx_ready),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: bytes waiting in the buffer plus the frame currently on the line.
    logic [7:0] m_buf[$];
    logic [7:0] exp_q[$];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;

    function automatic int exp_line();
        int b;
        if (!m_active) return 1;
        b = m_t / CPB;
        if (b == 0) return 0;
        if (b <= 8) return int'(m_byte[b-1]);
        return 1;
    endfunction

    always @(negedge clk) begin
        bit acc;
        if (rst) begin
            m_buf.delete();
            exp_q.delete();
            m_active = 1'b0;
            m_t = 0;
        end
        chk("tx_line", int'(tx), exp_line());
        chk("fifo_count", int'(fifo_count), m_buf.size());
        chk("tx_ready", int'(tx_ready), int'(m_buf.size() != DEPTH));
        chk("tx_busy", int'(tx_busy), int'(m_active || m_buf.size() != 0));
        if (!rst) begin
            acc = tx_data_valid && (m_buf.size() != DEPTH);
            if (m_active) begin
                if (m_t == FRAME - 1) m_active = 1'b0;
                else m_t++;
            end
            if (!m_active && m_buf.size() != 0) begin
                m_byte   = m_buf.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (acc) begin
                m_buf.push_back(tx_data);
                exp_q.push_back(tx_data);
            end
        end
    end

    // Line decoder: samples mid-bit and compares each completed frame with the scoreboard.
    bit         mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        int k;
        logic [7:0] e;
        if (rst) begin
            mon_busy = 1'b0;
        end else begin
            if (!mon_busy) begin
                if (tx == 1'b0) begin
                    mon_busy = 1'b1;
                    mon_cnt  = 0;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_busy) begin
                if (mon_cnt % CPB == CPB / 2) begin
                    k = mon_cnt / CPB;
                    if (k == 0) begin
                        chk("start_bit", int'(tx), 0);
                    end else if (k <= 8) begin
                        mon_byte[k-1] = tx;
                    end else begin
                        chk("stop_bit", int'(tx), 1);
                        if (exp_q.size() == 0) begin
                            chk("sb_unexpected_byte", int'(mon_byte), -1);
                        end else begin
                            e = exp_q.pop_front();
                            $display("frame rx=%02h expected=%02h at %0t", mon_byte, e, $time);
                            chk("sb_byte", int'(mon_byte), int'(e));
                        end
                    end
                end
                if (mon_cnt == FRAME - 1) mon_busy = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit acc;
        bit done;
        done = 1'b0;
        tx_data       = b;
        tx_data_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            acc = tx_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        tx_data_valid = 1'b0;
        chk("send_timeout", int'(done), 1);
    endtask

    task automatic wait_frame_cycle(input int target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_active && m_t == target) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("frame_cycle_timeout", int'(found), 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!tx_busy && exp_q.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", int'(done), 1);
        cycles(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset, with a byte offered that must be ignored.
        rst = 1'b1;
        tx_data = 8'hEE;
        tx_data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_busy", int'(tx_busy), 0);
        tx_data_valid = 1'b0;
        rst = 1'b0;
        cycles(5);
        chk("post_rst_idle_tx", int'(tx), 1);

        // Single byte: one cycle latency and exactly 100 busy cycles on the line.
        send(8'h55);
        chk("single_latency_pre", int'(tx), 1);
        cycles(1);
        chk("single_start_low", int'(tx), 0);
        n = 0;
        while (tx_busy && n < 1000) begin
            cycles(1);
            n++;
        end
        chk("single_busy_cycles", n, FRAME);
        drain();

        // Back-to-back frames.
        send(8'hA3);
        send(8'h0F);
        drain();

        // Full buffer, rejected write of 0xFF while full, then the sixth byte.
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h05);
        chk("full_count", int'(fifo_count), DEPTH);
        chk("full_ready", int'(tx_ready), 0);
        for (int i = 0; i < 30; i++) begin
            if (tx_ready) break;
            tx_data = 8'hFF;
            tx_data_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        tx_data_valid = 1'b0;
        chk("full_hold_count", int'(fifo_count), DEPTH);
        send(8'h06);
        drain();

        // Push on the very cycle STOP pops the next byte.
        send(8'h3C);
        send(8'hC3);
        send(8'h5A);
        chk("simul_pre_count", int'(fifo_count), 2);
        wait_frame_cycle(FRAME - 1);
        send(8'h96);
        chk("simul_post_count", int'(fifo_count), 2);
        drain();

        // Reset in the middle of a frame with two bytes buffered.
        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_frame_cycle(35);
        rst = 1'b1;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_ready", int'(tx_ready), 1);
        chk("midrst_busy", int'(tx_busy), 0);
        cycles(2);
        rst = 1'b0;
        cycles(150);
        chk("midrst_quiet_tx", int'(tx), 1);
        chk("midrst_quiet_busy", int'(tx_busy), 0);

        // Randomized traffic with gaps and bursts.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) cycles($urandom_range(1, 120));
            send(8'($urandom));
        end
        drain();
        chk("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
